// File: rtl/stp_frame_collector_if.sv
// Handshake/bus bundle for stp_frame_collector.
// master: the sample source / FFT core side; slave: the collector itself.
interface stp_frame_collector_if #(
    parameter int DATA_W = 16,
    parameter int NPTS   = 32,
    parameter int CNT_W  = $clog2(NPTS) + 1
);
    logic                   in_strobe;
    logic [DATA_W-1:0]      serial_in;
    logic                   frame_ack;
    logic                   flush;
    logic                   in_ready;
    logic                   frame_ready;
    logic [CNT_W-1:0]       sample_count;
    logic [NPTS*DATA_W-1:0] parallel_out;
    logic                   overrun;

    modport master (
        output in_strobe, serial_in, frame_ack, flush,
        input  in_ready, frame_ready, sample_count, parallel_out, overrun
    );

    modport slave (
        input  in_strobe, serial_in, frame_ack, flush,
        output in_ready, frame_ready, sample_count, parallel_out, overrun
    );
endinterface

// File: rtl/stp_frame_collector.sv
// Serial-to-parallel frame collector: fills NPTS slots in arrival order
// (slot 0 = first sample), holds the full frame until frame_ack.
// Optional sticky overrun detection is enabled by defining STP_OVERRUN_DETECT_EN;
// without it the overrun output is tied low.
module stp_frame_collector #(
    parameter int DATA_W = 16,
    parameter int NPTS   = 32,
    parameter int CNT_W  = $clog2(NPTS) + 1
) (
    input logic                   clk,
    input logic                   n_rst,
    stp_frame_collector_if.slave  bus
);
    localparam int IDX_W = $clog2(NPTS);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  count_q;
    logic              frame_ready_q;
    logic              in_ready_q;
    logic [DATA_W-1:0] slot_q [NPTS];
    logic [IDX_W-1:0]  wr_idx;

    // Count never reaches NPTS while filling, so the low bits address the slot.
    assign wr_idx = count_q[IDX_W-1:0];

    // Frame FSM with registered status outputs and slot storage.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= FILL;
            count_q       <= '0;
            frame_ready_q <= 1'b0;
            in_ready_q    <= 1'b1;
            for (int unsigned i = 0; i < NPTS; i++) begin
                slot_q[i] <= '0;
            end
        end else if (bus.flush) begin
            state_q       <= FILL;
            count_q       <= '0;
            frame_ready_q <= 1'b0;
            in_ready_q    <= 1'b1;
        end else begin
            case (state_q)
                FILL: begin
                    if (bus.in_strobe) begin
                        slot_q[wr_idx] <= bus.serial_in;
                        count_q        <= count_q + 1'b1;
                        if (wr_idx == IDX_W'(NPTS - 1)) begin
                            state_q       <= HOLD;
                            frame_ready_q <= 1'b1;
                            in_ready_q    <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (bus.frame_ack) begin
                        state_q       <= FILL;
                        count_q       <= '0;
                        frame_ready_q <= 1'b0;
                        in_ready_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= FILL;
                end
            endcase
        end
    end

`ifdef STP_OVERRUN_DETECT_EN
    logic overrun_q;

    // Sticky flag: a strobe offered while the frame is held; cleared by flush.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            overrun_q <= 1'b0;
        end else if (bus.flush) begin
            overrun_q <= 1'b0;
        end else if (state_q == HOLD && bus.in_strobe) begin
            overrun_q <= 1'b1;
        end
    end

    assign bus.overrun = overrun_q;
`else
    assign bus.overrun = 1'b0;
`endif

    // Flatten slot storage onto the parallel bus, slot k at [k*DATA_W +: DATA_W].
    always_comb begin
        bus.parallel_out = '0;
        for (int unsigned k = 0; k < NPTS; k++) begin
            bus.parallel_out[k*DATA_W +: DATA_W] = slot_q[k];
        end
    end

    assign bus.sample_count = count_q;
    assign bus.frame_ready  = frame_ready_q;
    assign bus.in_ready     = in_ready_q;
endmodule

// File: tb/tb_stp_frame_collector.sv
// Self-checking bench for stp_frame_collector against a frame-level model.
module tb_stp_frame_collector;
    localparam int DATA_W = 16;
    localparam int NPTS   = 32;
    localparam int CNT_W  = $clog2(NPTS) + 1;
`ifdef STP_OVERRUN_DETECT_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic n_rst = 1'b0;

    stp_frame_collector_if #(.DATA_W(DATA_W), .NPTS(NPTS), .CNT_W(CNT_W)) bus ();

    stp_frame_collector #(.DATA_W(DATA_W), .NPTS(NPTS), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: what the frame should look like after each clock.
    logic [DATA_W-1:0] m_slot [NPTS];
    int  m_count;
    bit  m_full;
    bit  m_ovr;
    int  n_cmp = 0;
    int  n_err = 0;
    int  rises = 0;
    bit  prev_fr = 1'b0;

    task automatic chk(input string tag, input logic [NPTS*DATA_W-1:0] obs,
                       input logic [NPTS*DATA_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NPTS*DATA_W-1:0] exp_bus();
        logic [NPTS*DATA_W-1:0] v;
        for (int k = 0; k < NPTS; k++) v[k*DATA_W +: DATA_W] = m_slot[k];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NPTS; k++) m_slot[k] = '0;
        m_count = 0;
        m_full  = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic check_all();
        chk("sample_count", NPTS*DATA_W'(bus.sample_count), NPTS*DATA_W'(m_count));
        chk("frame_ready",  NPTS*DATA_W'(bus.frame_ready),  NPTS*DATA_W'(m_full));
        chk("in_ready",     NPTS*DATA_W'(bus.in_ready),     NPTS*DATA_W'(!m_full));
        chk("overrun",      NPTS*DATA_W'(bus.overrun),      NPTS*DATA_W'(m_ovr));
        chk("parallel_out", bus.parallel_out, exp_bus());
        if (bus.frame_ready === 1'b1 && !prev_fr) rises++;
        prev_fr = (bus.frame_ready === 1'b1);
    endtask

    // One clock: check the state left by the previous edge, then drive inputs
    // and advance the model to what the next edge should produce.
    task automatic step(input bit s, input logic [DATA_W-1:0] d, input bit a, input bit f);
        @(negedge clk);
        check_all();
        bus.in_strobe = s;
        bus.serial_in = d;
        bus.frame_ack = a;
        bus.flush     = f;
        if (f) begin
            m_count = 0;
            m_full  = 1'b0;
            m_ovr   = 1'b0;
        end else if (m_full) begin
            if (s && OVR_EN) m_ovr = 1'b1;
            if (a) begin
                m_full  = 1'b0;
                m_count = 0;
            end
        end else if (s) begin
            m_slot[m_count] = d;
            m_count++;
            if (m_count == NPTS) m_full = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [DATA_W-1:0] r;
        bus.in_strobe = 1'b0;
        bus.serial_in = '0;
        bus.frame_ack = 1'b0;
        bus.flush     = 1'b0;
        model_reset();

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        idle(1);

        // First frame, incrementing pattern.
        for (int k = 0; k < NPTS; k++) step(1'b1, DATA_W'(16'h0100 + k), 1'b0, 1'b0);
        idle(2);

        // Strobes while held, then ack.
        for (int i = 0; i < 3; i++) step(1'b1, 16'hDEAD, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Second frame right after ack, random idle gaps.
        rises = 0;
        for (int k = 0; k < NPTS; k++) begin
            step(1'b1, DATA_W'(16'h2000 + k), 1'b0, 1'b0);
            idle(int'($urandom_range(0, 3)));
        end
        idle(2);
        chk("frame_ready_rises", NPTS*DATA_W'(rises), NPTS*DATA_W'(1));
        // Ack with a same-cycle strobe: strobe must be dropped.
        step(1'b1, 16'hBEEF, 1'b1, 1'b0);

        // 10 random samples, flush with a same-cycle strobe, then one sample.
        for (int k = 0; k < 10; k++) begin
            r = DATA_W'($urandom);
            step(1'b1, r, 1'b0, 1'b0);
        end
        step(1'b1, 16'hFFFF, 1'b0, 1'b1);
        step(1'b1, 16'h5A5A, 1'b0, 1'b0);
        idle(1);

        // 20 samples, then asynchronous reset mid-cycle.
        for (int k = 0; k < 20; k++) begin
            r = DATA_W'($urandom);
            step(1'b1, r, 1'b0, 1'b0);
        end
        @(negedge clk);
        bus.in_strobe = 1'b0;
        bus.frame_ack = 1'b0;
        bus.flush     = 1'b0;
        #2 n_rst = 1'b0;
        #1;
        model_reset();
        chk("rst_parallel_out", bus.parallel_out, exp_bus());
        chk("rst_sample_count", NPTS*DATA_W'(bus.sample_count), NPTS*DATA_W'(0));
        chk("rst_frame_ready",  NPTS*DATA_W'(bus.frame_ready),  NPTS*DATA_W'(0));
        #1 n_rst = 1'b1;
        idle(1);

        // Full random frame after reset, then ack.
        for (int k = 0; k < NPTS; k++) begin
            r = DATA_W'($urandom);
            step(1'b1, r, 1'b0, 1'b0);
        end
        idle(1);
        step(1'b0, '0, 1'b1, 1'b0);

        // Ack during FILL is ignored.
        for (int k = 0; k < 5; k++) begin
            r = DATA_W'($urandom);
            step(1'b1, r, 1'b0, 1'b0);
        end
        step(1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < NPTS - 5; k++) begin
            r = DATA_W'($urandom);
            step(1'b1, r, 1'b0, 1'b0);
        end
        idle(2);
        step(1'b0, '0, 1'b1, 1'b0);
        idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/stp_frame_collector.md
Name: stp_frame_collector

Overview:
- Serial-to-parallel frame collector on the input side of the FFT datapath.
- Accepts one DATA_W-bit sample per strobe and fills NPTS slots in arrival order.
- Presents the completed frame as one wide parallel bus, then holds it until the FFT core acknowledges it.
- Complements the output-side parallel-to-serial stage: slot 0 is the first sample received.

Parameters:
- DATA_W, 16, sample width in bits.
- NPTS, 32, samples per frame; power of two, at least 2.
- CNT_W, $clog2(NPTS)+1, width of sample_count.

Ports:
- clk  input  1  clock.
- n_rst  input  1  reset, asynchronous, active-low.
- in_strobe  input  1  active-high; serial_in is valid this cycle.
- serial_in  input  DATA_W  incoming sample.
- frame_ack  input  1  active-high, one cycle; FFT core has consumed parallel_out.
- flush  input  1  synchronous clear of the current frame; highest priority after reset.
- in_ready  output  1  high when a strobe will be accepted.
- frame_ready  output  1  high while a complete frame is held on parallel_out.
- sample_count  output  CNT_W  number of samples stored in the current frame, 0..NPTS.
- parallel_out  output  NPTS*DATA_W  slot k at bits [k*DATA_W +: DATA_W].
- overrun  output  1  sticky overrun flag; see Optional Feature.

Behaviour:
- Reset (n_rst=0, asynchronous):
  - All slots 0, so parallel_out=0.
  - sample_count=0, frame_ready=0, in_ready=1, overrun=0.
  - State FILL.
- All outputs are registered. No combinational path from inputs to outputs.
- FILL state, in_ready=1, frame_ready=0:
  - in_strobe=1 writes serial_in to slot[sample_count] and increments sample_count.
  - The strobe that writes slot NPTS-1 moves the block to HOLD. In the following cycle sample_count=NPTS, frame_ready=1, in_ready=0.
  - Latency from the last strobe to frame_ready is 1 cycle.
  - frame_ack in FILL is ignored.
- HOLD state, in_ready=0, frame_ready=1:
  - parallel_out is stable.
  - in_strobe is ignored; the sample is dropped and the slots are unchanged.
  - frame_ack=1 moves the block to FILL. In the next cycle sample_count=0, frame_ready=0, in_ready=1.
  - A strobe in the same cycle as frame_ack is dropped, because in_ready was 0 during that cycle.
- Slots are not cleared on ack or flush. Stale data stays on parallel_out until overwritten. Consumers qualify parallel_out only with frame_ready.
- flush=1, in any state:
  - Next cycle: FILL, sample_count=0, frame_ready=0, in_ready=1.
  - A strobe or ack in the same cycle is ignored.
  - overrun is cleared.
- sample_count never exceeds NPTS. Slot index wraps only via ack or flush, never by counting.
- Reset asserted mid-frame clears everything immediately. Partial frames are discarded.
- Back-to-back frames: the first sample of the next frame is accepted no earlier than 1 cycle after frame_ack.

Optional Feature:
- Macro: STP_OVERRUN_DETECT_EN.
- With the macro defined:
  - in_strobe=1 while in HOLD sets overrun=1 in the next cycle.
  - overrun stays set through later frames.
  - overrun clears only on reset or flush.
- Without the macro:
  - overrun is tied to 0.
  - No detection logic is synthesized.
  - The port remains so that integration is identical in both builds.

Test Plan:
- Reset, then 32 strobes with serial_in=16'h0100+k (k=0..31) -> frame_ready=1 one cycle after the 32nd strobe; slot k=16'h0100+k; sample_count=32; in_ready=0.
- Frame held, 3 strobes with 16'hDEAD, then frame_ack -> parallel_out unchanged; with STP_OVERRUN_DETECT_EN, overrun=1 one cycle after the first strobe, else 0; after ack, frame_ready=0, sample_count=0, in_ready=1.
- Second frame of 32 samples 16'h2000+k strobed immediately after ack, with gaps of 0-3 idle cycles -> slots hold exactly 16'h2000+k; frame_ready raised exactly once.
- 10 samples, then flush=1 with in_strobe=1 in the same cycle -> sample_count=0 next cycle; the strobe is dropped; the next accepted sample goes to slot 0; overrun=0.
- 20 samples, then n_rst pulsed low mid-cycle -> parallel_out=0, sample_count=0, frame_ready=0 asynchronously; a subsequent full 32-sample frame completes normally.
- frame_ack pulsed during FILL after 5 samples -> no effect; sample_count=5; the frame completes after 27 more strobes.
